// File: rtl/clk_div_timer.sv
// Programmable terminal-count divider/timer: one-cycle tick enable plus a
// square wave at a runtime-loadable ratio, in periodic or one-shot mode.
module clk_div_timer #(
  parameter int unsigned WIDTH       = 28,
  parameter int unsigned DEFAULT_DIV = 25000000
) (
  input  logic             clk,
  input  logic             clear,
  input  logic             en,
  input  logic             start,
  input  logic             stop,
  input  logic             mode,
  input  logic             load,
  input  logic [WIDTH-1:0] div_val,
  output logic             tick,
  output logic             sq_out,
  output logic             busy,
  output logic [WIDTH-1:0] cnt
);

  typedef enum logic {IDLE = 1'b0, RUN = 1'b1} state_t;

  state_t           r_state, w_state_nxt;
  logic [WIDTH-1:0] r_cnt,   w_cnt_nxt;
  logic [WIDTH-1:0] r_div,   w_div_nxt;
  logic             r_tick,  w_tick_nxt;
  logic             r_sq,    w_sq_nxt;
  logic             w_term;

  // Only meaningful in RUN, where r_div is guaranteed non-zero.
  assign w_term = (r_cnt == (r_div - WIDTH'(1)));

  always_ff @(posedge clk or posedge clear) begin
    if (clear) begin
      r_state <= IDLE;
      r_cnt   <= '0;
      r_div   <= WIDTH'(DEFAULT_DIV);
      r_tick  <= 1'b0;
      r_sq    <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
      r_div   <= w_div_nxt;
      r_tick  <= w_tick_nxt;
      r_sq    <= w_sq_nxt;
    end
  end

  // Priority: stop > load > start > count.
  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_div_nxt   = r_div;
    w_tick_nxt  = 1'b0;
    w_sq_nxt    = r_sq;
    if (stop) begin
      w_state_nxt = IDLE;
      w_cnt_nxt   = '0;
      w_sq_nxt    = 1'b0;
    end else if (load) begin
      w_div_nxt = div_val;
      w_cnt_nxt = '0;
      if (div_val == '0) w_state_nxt = IDLE;
    end else if (start) begin
      if (r_div != '0) begin
        w_state_nxt = RUN;
        w_cnt_nxt   = '0;
      end
    end else if (r_state == RUN && en) begin
      if (w_term) begin
        w_cnt_nxt  = '0;
        w_tick_nxt = 1'b1;
        w_sq_nxt   = ~r_sq;
        if (mode) w_state_nxt = IDLE;
      end else begin
        w_cnt_nxt = r_cnt + WIDTH'(1);
      end
    end
  end

  assign tick   = r_tick;
  assign sq_out = r_sq;
  assign busy   = (r_state == RUN);
  assign cnt    = r_cnt;

endmodule

// File: tb/tb_clk_div_timer.sv
// Directed bench for clk_div_timer; expected values are hand-derived per step.
module tb_clk_div_timer;
  localparam int W = 28;

  logic         clk = 1'b0;
  logic         clear, en, start, stop, mode, load;
  logic [W-1:0] div_val;
  logic         tick, sq_out, busy;
  logic [W-1:0] cnt;

  int nvec = 0;
  int nerr = 0;

  clk_div_timer #(.WIDTH(W), .DEFAULT_DIV(7)) dut (
    .clk(clk), .clear(clear), .en(en), .start(start), .stop(stop),
    .mode(mode), .load(load), .div_val(div_val),
    .tick(tick), .sq_out(sq_out), .busy(busy), .cnt(cnt)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    nvec++;
    assert (obs === exp) else begin
      nerr++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic chk_all(input string tag, input logic t, input logic s,
                         input logic b, input logic [W-1:0] c);
    chk({tag, ".tick"}, 32'(tick), 32'(t));
    chk({tag, ".sq"},   32'(sq_out), 32'(s));
    chk({tag, ".busy"}, 32'(busy), 32'(b));
    chk({tag, ".cnt"},  32'(cnt), 32'(c));
  endtask

  task automatic do_load(input logic [W-1:0] v);
    load = 1'b1; div_val = v; step(); load = 1'b0;
  endtask

  task automatic do_start();
    start = 1'b1; step(); start = 1'b0;
  endtask

  task automatic do_stop();
    stop = 1'b1; step(); stop = 1'b0;
  endtask

  initial begin
    clear = 1'b1; en = 1'b0; start = 1'b0; stop = 1'b0;
    mode = 1'b0; load = 1'b0; div_val = '0;
    step(); step();
    chk_all("reset", 0, 0, 0, 0);

    // Default divisor 7: tick after the 7th enabled edge following start.
    clear = 1'b0; en = 1'b1;
    do_start();
    chk_all("def_start", 0, 0, 1, 0);
    for (int k = 1; k <= 6; k++) step();
    chk_all("def_pre", 0, 0, 1, 6);
    step();
    chk_all("def_tick", 1, 1, 1, 0);
    step(); step();
    chk("def_cnt2", 32'(cnt), 2);
    // Asynchronous clear mid-count.
    #2 clear = 1'b1;
    #1;
    chk_all("clr_async", 0, 0, 0, 0);
    step();
    chk_all("clr_hold", 0, 0, 0, 0);
    clear = 1'b0;

    // Periodic N=4.
    do_load(4);
    chk_all("p4_load", 0, 0, 0, 0);
    do_start();
    chk_all("p4_start", 0, 0, 1, 0);
    for (int k = 1; k <= 16; k++) begin
      step();
      chk_all("p4_run", (k % 4) == 0, ((k / 4) % 2) == 1, 1, W'(k % 4));
    end
    do_stop();
    chk_all("p4_stop", 0, 0, 0, 0);

    // One-shot N=5.
    do_load(5);
    mode = 1'b1;
    do_start();
    for (int k = 1; k <= 4; k++) begin
      step();
      chk_all("os_run", 0, 0, 1, W'(k));
    end
    step();
    chk_all("os_tick", 1, 1, 0, 0);
    for (int k = 0; k < 20; k++) begin
      step();
      chk_all("os_after", 0, 1, 0, 0);
    end
    mode = 1'b0;

    // Pause at cnt=2 for 3 cycles, N=6.
    do_stop();
    do_load(6);
    do_start();
    step(); step();
    chk("pz_cnt2", 32'(cnt), 2);
    en = 1'b0;
    for (int k = 0; k < 3; k++) begin
      step();
      chk_all("pz_hold", 0, 0, 1, 2);
    end
    en = 1'b1;
    for (int k = 3; k <= 5; k++) begin
      step();
      chk_all("pz_resume", 0, 0, 1, W'(k));
    end
    step();
    chk_all("pz_tick", 1, 1, 1, 0);

    // Load 3 on the terminal-count cycle of N=4: no tick, then period 3.
    do_stop();
    do_load(4);
    do_start();
    step(); step(); step();
    chk("col_term", 32'(cnt), 3);
    do_load(3);
    chk_all("col_load", 0, 0, 1, 0);
    for (int k = 1; k <= 6; k++) begin
      step();
      chk_all("col_run", (k % 3) == 0, ((k / 3) % 2) == 1, 1, W'(k % 3));
    end

    // start and stop together: stop wins.
    start = 1'b1; stop = 1'b1; step(); start = 1'b0; stop = 1'b0;
    chk_all("ss", 0, 0, 0, 0);

    // N=1 periodic.
    do_load(1);
    do_start();
    for (int k = 1; k <= 6; k++) begin
      step();
      chk_all("n1", 1, (k % 2) == 1, 1, 0);
    end

    // Load 0 while running forces IDLE; start then ignored.
    do_load(0);
    chk_all("n0_load", 0, 0, 0, 0);
    do_start();
    chk_all("n0_start", 0, 0, 0, 0);
    for (int k = 0; k < 4; k++) begin
      step();
      chk_all("n0_idle", 0, 0, 0, 0);
    end

    // Switch periodic -> one-shot at cnt=1 with N=4.
    do_load(4);
    do_start();
    step();
    chk("ms_cnt1", 32'(cnt), 1);
    mode = 1'b1;
    step(); step();
    chk_all("ms_pre", 0, 0, 1, 3);
    step();
    chk_all("ms_tick", 1, 1, 0, 0);
    for (int k = 0; k < 5; k++) begin
      step();
      chk_all("ms_after", 0, 1, 0, 0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end
endmodule
